// File: rtl/timer_ctrl_if.sv
// timer_ctrl_if: link between timer_ctrl and the seconds-ones countdown digit.
// master = timer_ctrl side (drives enable/done), slave = seconds counter side.
interface timer_ctrl_if;
  logic [3:0] SEC_VAL;
  logic       SEC_TICK;
  logic       SEC_BUSY;
  logic       CNT_EN;
  logic       CNT_DONE;

  modport master (
    input  SEC_VAL, SEC_TICK, SEC_BUSY,
    output CNT_EN, CNT_DONE
  );

  modport slave (
    output SEC_VAL, SEC_TICK, SEC_BUSY,
    input  CNT_EN, CNT_DONE
  );
endinterface

// File: rtl/timer_ctrl.sv
// timer_ctrl: countdown sequencer for the tens-of-seconds and minutes digits,
// sitting downstream of the seconds-ones counter. Handles start/pause and
// clear/abort buttons and raises ALARM when the display reaches 0:00.
// Optional feature macro: TIMER_ALARM_AUTOCLR_EN -- when defined, ALARM clears
// itself after ALARM_CYCLES cycles; otherwise it holds until clear or RST.
module timer_ctrl #(
  parameter int unsigned ALARM_CYCLES = 300_000_000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         BTN_START,
  input  logic         BTN_CLR,
  input  logic [2:0]   SET_TENS,
  input  logic [3:0]   SET_MIN,
  timer_ctrl_if.master cnt,
  output logic [2:0]   TENS,
  output logic [3:0]   MIN,
  output logic         ALARM,
  output logic         RUNNING
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_PAUSE  = 3'd2;
  localparam logic [2:0] S_ABORT1 = 3'd3;
  localparam logic [2:0] S_ABORT2 = 3'd4;
  localparam logic [2:0] S_ALARM  = 3'd5;

  logic [2:0] state;
  logic       start_lvl;
  logic       clr_lvl;
  logic       start_p;
  logic       clr_p;
  logic       zero;
  logic       borrow;
  logic       auto_clr;

  // Button edge detection: previous level plus a registered one-cycle pulse.
  always_ff @(posedge CLK) begin
    // NOTE: RST is synchronous, so it is tested inside the clocked block and
    // is deliberately absent from the sensitivity list.
    if (RST) begin
      start_lvl <= 1'b0;
      clr_lvl   <= 1'b0;
      start_p   <= 1'b0;
      clr_p     <= 1'b0;
    end else begin
      start_lvl <= BTN_START;
      clr_lvl   <= BTN_CLR;
      start_p   <= BTN_START & ~start_lvl;
      clr_p     <= BTN_CLR & ~clr_lvl;
    end
  end

  // Display at 0:00 right now; borrow only when there is something to borrow from.
  assign zero   = (cnt.SEC_VAL == 4'd0) && (TENS == 3'd0) && (MIN == 4'd0);
  assign borrow = cnt.SEC_TICK && (cnt.SEC_VAL == 4'd0) &&
                  !((TENS == 3'd0) && (MIN == 4'd0));

`ifdef TIMER_ALARM_AUTOCLR_EN
  logic [31:0] alarm_cnt;

  // Cycles spent in ALARM; held at zero everywhere else so it restarts on entry.
  always_ff @(posedge CLK) begin
    if (RST || (state != S_ALARM)) begin
      alarm_cnt <= 32'd0;
    end else begin
      alarm_cnt <= alarm_cnt + 32'd1;
    end
  end

  assign auto_clr = (state == S_ALARM) && (alarm_cnt == ALARM_CYCLES - 32'd1);
`else
  // ALARM_CYCLES only matters with auto-clear; fold it away here.
  logic unused_alarm_cycles;
  assign unused_alarm_cycles = ^ALARM_CYCLES;
  assign auto_clr = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      cnt.CNT_EN   <= 1'b0;
      cnt.CNT_DONE <= 1'b0;
      TENS         <= 3'd0;
      MIN          <= 4'd0;
      ALARM        <= 1'b0;
      RUNNING      <= 1'b0;
    end else begin
      // NOTE: default-low each cycle so CNT_DONE can only ever be a one-cycle
      // strobe; a later assignment in the case below wins for that cycle.
      cnt.CNT_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_p && !cnt.SEC_BUSY) begin
            TENS       <= (SET_TENS > 3'd5) ? 3'd5 : SET_TENS;
            MIN        <= (SET_MIN > 4'd9) ? 4'd9 : SET_MIN;
            cnt.CNT_EN <= 1'b1;
            RUNNING    <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (clr_p) begin
            RUNNING <= 1'b0;
            state   <= S_ABORT1;
          end else if (zero) begin
            cnt.CNT_DONE <= 1'b1;
            ALARM        <= 1'b1;
            RUNNING      <= 1'b0;
            state        <= S_ALARM;
          end else if (start_p) begin
            cnt.CNT_EN <= 1'b0;
            RUNNING    <= 1'b0;
            state      <= S_PAUSE;
          end else if (borrow) begin
            if (TENS != 3'd0) begin
              TENS <= TENS - 3'd1;
            end else begin
              TENS <= 3'd5;
              MIN  <= MIN - 4'd1;
            end
          end
        end
        S_PAUSE: begin
          if (clr_p) begin
            cnt.CNT_EN <= 1'b1;
            state      <= S_ABORT1;
          end else if (start_p) begin
            cnt.CNT_EN <= 1'b1;
            RUNNING    <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_ABORT1: begin
          // Counter is running again; now tell it to finish.
          cnt.CNT_DONE <= 1'b1;
          state        <= S_ABORT2;
        end
        S_ABORT2: begin
          cnt.CNT_EN <= 1'b0;
          TENS       <= 3'd0;
          MIN        <= 4'd0;
          state      <= S_IDLE;
        end
        S_ALARM: begin
          if (clr_p || auto_clr) begin
            ALARM      <= 1'b0;
            cnt.CNT_EN <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          cnt.CNT_EN <= 1'b0;
          RUNNING    <= 1'b0;
          ALARM      <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: self-checking bench for timer_ctrl with a behavioural
// seconds-ones counter (digit 0..9, one tick every TICK_PERIOD cycles).
module tb_timer_ctrl;
  localparam int TICK_PERIOD = 8;
  localparam int CNT_FULL    = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_START = 1'b0;
  logic       BTN_CLR = 1'b0;
  logic [2:0] SET_TENS = 3'd0;
  logic [3:0] SET_MIN = 4'd0;
  logic [2:0] TENS;
  logic [3:0] MIN;
  logic       ALARM;
  logic       RUNNING;

  timer_ctrl_if sec_if ();

  timer_ctrl #(.ALARM_CYCLES(20)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_START (BTN_START),
    .BTN_CLR   (BTN_CLR),
    .SET_TENS  (SET_TENS),
    .SET_MIN   (SET_MIN),
    .cnt       (sec_if),
    .TENS      (TENS),
    .MIN       (MIN),
    .ALARM     (ALARM),
    .RUNNING   (RUNNING)
  );

  always #5 CLK = ~CLK;

  // Behavioural seconds-ones counter.
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_HOLD, C_DONE} cstate_t;
  cstate_t    cst;
  logic [3:0] cval;
  int         div;
  logic [3:0] preset = 4'd0;
  logic       busy_force = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      cst  <= C_IDLE;
      cval <= preset;
      div  <= 0;
    end else begin
      case (cst)
        C_IDLE: begin
          cval <= preset;
          div  <= 0;
          if (sec_if.CNT_EN) cst <= C_RUN;
        end
        C_RUN: begin
          if (sec_if.CNT_DONE) cst <= C_DONE;
          else if (!sec_if.CNT_EN) cst <= C_HOLD;
          else if (div == TICK_PERIOD - 1) begin
            div  <= 0;
            cval <= (cval == 4'd0) ? 4'(CNT_FULL - 1) : cval - 4'd1;
          end else begin
            div <= div + 1;
          end
        end
        C_HOLD: begin
          if (sec_if.CNT_DONE) cst <= C_DONE;
          else if (sec_if.CNT_EN) cst <= C_RUN;
        end
        default: begin
          if (!sec_if.CNT_EN) cst <= C_IDLE;
        end
      endcase
    end
  end

  assign sec_if.SEC_VAL  = cval;
  assign sec_if.SEC_TICK = (cst == C_RUN) && (div == TICK_PERIOD - 1);
  assign sec_if.SEC_BUSY = (cst != C_IDLE) || busy_force;

  logic [10:0] outs;
  assign outs = {sec_if.CNT_EN, sec_if.CNT_DONE, TENS, MIN, ALARM, RUNNING};

  typedef struct packed {
    logic [3:0] min;
    logic [2:0] tens;
    logic [3:0] ones;
  } disp_t;

  disp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge: button high across exactly one rising edge.
  task automatic pulse_btn(input bit clr);
    if (clr) BTN_CLR = 1'b1;
    else BTN_START = 1'b1;
    @(negedge CLK);
    BTN_CLR   = 1'b0;
    BTN_START = 1'b0;
  endtask

  task automatic wait_en_low(input string tag);
    for (int w = 0; w < 10; w++) begin
      if (!sec_if.CNT_EN) break;
      @(negedge CLK);
    end
    check(tag, sec_if.CNT_EN, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    disp_t d;
    int    rem;
    bit    got_tick;
    bit    timeout;
    bit    paused;
    int    en_hi;
    int    frz_bad;
    int    alarm_len;

    // Reset
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", 32'(outs), 0);
    RST = 1'b0;
    @(negedge CLK);

    // Start ignored while the seconds counter is busy
    busy_force = 1'b1;
    pulse_btn(1'b0);
    repeat (3) @(negedge CLK);
    check("busy_ignore_en", sec_if.CNT_EN, 0);
    check("busy_ignore_running", RUNNING, 0);
    busy_force = 1'b0;
    @(negedge CLK);

    // Full countdown from 1:10 with the expected display after every tick
    SET_MIN  = 4'd1;
    SET_TENS = 3'd1;
    for (int k = 1; k <= 70; k++) begin
      rem    = 70 - k;
      d.min  = 4'(rem / 60);
      d.tens = 3'((rem % 60) / 10);
      d.ones = 4'(rem % 10);
      exp_q.push_back(d);
    end
    pulse_btn(1'b0);
    check("start_edge1_en", sec_if.CNT_EN, 0);
    @(negedge CLK);
    check("start_edge2_en", sec_if.CNT_EN, 1);
    check("load_digits", 32'({MIN, TENS}), 32'({4'd1, 3'd1}));
    check("load_running", RUNNING, 1);

    paused  = 1'b0;
    timeout = 1'b0;
    for (int k = 1; k <= 70 && !timeout; k++) begin
      got_tick = 1'b0;
      for (int w = 0; w < 100; w++) begin
        @(negedge CLK);
        if (sec_if.SEC_TICK) begin
          got_tick = 1'b1;
          break;
        end
      end
      if (!got_tick) begin
        check("tick_timeout", 0, 1);
        timeout = 1'b1;
      end else begin
        @(negedge CLK);
        d = exp_q.pop_front();
        check("display", 32'({MIN, TENS, sec_if.SEC_VAL}), 32'(d));
        if (!paused && d.min == 4'd0 && d.tens == 3'd4 && d.ones == 4'd5) begin
          // Pause at 0:45
          pulse_btn(1'b0);
          wait_en_low("pause_enter_en");
          en_hi   = 0;
          frz_bad = 0;
          repeat (50) begin
            @(negedge CLK);
            if (sec_if.CNT_EN) en_hi++;
            if ({MIN, TENS} != {4'd0, 3'd4}) frz_bad++;
          end
          check("pause_en_low", en_hi, 0);
          check("pause_frozen", frz_bad, 0);
          check("pause_running", RUNNING, 0);
          pulse_btn(1'b0);
          @(negedge CLK);
          check("resume_en", sec_if.CNT_EN, 1);
          check("resume_running", RUNNING, 1);
          paused = 1'b1;
        end
      end
    end
    check("scoreboard_empty", exp_q.size(), 0);

    // Zero detect: this is the cycle showing 0:00
    check("zero_cycle_done", sec_if.CNT_DONE, 0);
    check("zero_cycle_alarm", ALARM, 0);
    @(negedge CLK);
    check("done_strobe", sec_if.CNT_DONE, 1);
    check("alarm_set", ALARM, 1);
    check("alarm_running", RUNNING, 0);
    check("alarm_en", sec_if.CNT_EN, 1);
    @(negedge CLK);
    check("done_one_cycle", sec_if.CNT_DONE, 0);
    check("alarm_digits", 32'({ALARM, MIN, TENS}), 32'({1'b1, 4'd0, 3'd0}));

`ifdef TIMER_ALARM_AUTOCLR_EN
    alarm_len = 2;
    for (int w = 0; w < 200; w++) begin
      @(negedge CLK);
      if (!ALARM) break;
      alarm_len++;
    end
    check("autoclr_len", alarm_len, 20);
    check("autoclr_en", sec_if.CNT_EN, 0);
`else
    alarm_len = 0;
    repeat (100) begin
      @(negedge CLK);
      if (!ALARM) alarm_len++;
    end
    check("alarm_hold", alarm_len, 0);
    pulse_btn(1'b1);
    check("alarm_clr_edge1", ALARM, 1);
    @(negedge CLK);
    check("alarm_clr_edge2", ALARM, 0);
    check("alarm_clr_en", sec_if.CNT_EN, 0);
`endif
    repeat (4) @(negedge CLK);

    // Abort from PAUSE
    SET_MIN  = 4'd0;
    SET_TENS = 3'd3;
    pulse_btn(1'b0);
    @(negedge CLK);
    check("abort_start_running", RUNNING, 1);
    repeat (20) @(negedge CLK);
    pulse_btn(1'b0);
    wait_en_low("abort_pause_en");
    repeat (5) @(negedge CLK);
    pulse_btn(1'b1);
    check("abort_n_en", sec_if.CNT_EN, 0);
    @(negedge CLK);
    check("abort_n1", 32'({sec_if.CNT_EN, sec_if.CNT_DONE}), 32'(2'b10));
    @(negedge CLK);
    check("abort_n2", 32'({sec_if.CNT_EN, sec_if.CNT_DONE}), 32'(2'b11));
    @(negedge CLK);
    check("abort_n3", 32'(outs), 0);
    @(negedge CLK);
    check("abort_done_single", sec_if.CNT_DONE, 0);
    check("abort_counter_idle", sec_if.SEC_BUSY, 0);
    repeat (2) @(negedge CLK);

    // Clamp of illegal presets, then RST mid-run
    SET_TENS = 3'd7;
    SET_MIN  = 4'd12;
    pulse_btn(1'b0);
    @(negedge CLK);
    check("clamp_digits", 32'({MIN, TENS}), 32'({4'd9, 3'd5}));
    check("clamp_running", 32'({sec_if.CNT_EN, RUNNING}), 32'(2'b11));
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrun_reset", 32'(outs), 0);
    RST = 1'b0;
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
